// File: rtl/msj_pid_update_scheduler_if.sv
// rtl/msj_pid_update_scheduler_if.sv - start/done handshake between the scheduler and the shared PID core
interface msj_pid_update_scheduler_if #(
  parameter int MOTOR_ID_WIDTH = 3
);
  logic                      start;
  logic [MOTOR_ID_WIDTH-1:0] motor_id;
  logic                      done;
  logic signed [31:0]        result_duty;

  // scheduler side
  modport master (
    output start,
    output motor_id,
    input  done,
    input  result_duty
  );

  // PID core side
  modport slave (
    input  start,
    input  motor_id,
    output done,
    output result_duty
  );
endinterface

// File: rtl/msj_pid_update_scheduler.sv
// rtl/msj_pid_update_scheduler.sv - round-robin scheduler sharing one PID core across motor channels
module msj_pid_update_scheduler #(
  parameter int NUMBER_OF_MOTORS = 8,
  parameter int MOTOR_ID_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUMBER_OF_MOTORS-1:0]    update_request,
  input  logic [NUMBER_OF_MOTORS-1:0]    enable,
  msj_pid_update_scheduler_if.master     core,
  output logic [32*NUMBER_OF_MOTORS-1:0] duty,
  output logic [NUMBER_OF_MOTORS-1:0]    duty_valid,
  output logic                           busy,
  output logic [31:0]                    overrun_count,
  output logic [15:0]                    timeout_count,
  input  logic                           clear_counters
);

  localparam int N           = NUMBER_OF_MOTORS;
  localparam int MW          = MOTOR_ID_WIDTH;
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [TIMER_WIDTH-1:0] timer_q;
  logic [N-1:0]           pending_q;
  logic [N-1:0]           pending_d;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           grant_vec;
  logic [N-1:0]           accept_vec;
  logic [N-1:0]           overrun_vec;
  logic [N-1:0]           upper_mask;
  logic [N-1:0]           upper_pending;
  logic [MW-1:0]          motor_id_q;
  logic [MW-1:0]          last_grant_q;
  logic [MW-1:0]          sel;
  logic [MW-1:0]          sel_upper;
  logic [MW-1:0]          sel_any;
  logic                   grant_fire;
  logic                   accept;
  logic                   timed_out;
  logic [N-1:0][31:0]     duty_q;
  logic [N-1:0]           duty_valid_q;
  logic [31:0]            overrun_q;
  logic [31:0]            overrun_inc;
  logic [32:0]            overrun_sum;
  logic [15:0]            timeout_q;

  // Round-robin pick: lowest pending index above last_grant, else wrap to lowest pending overall
  always_comb begin
    upper_mask = '0;
    sel_upper  = '0;
    sel_any    = '0;
    for (int k = 0; k < N; k++) begin
      upper_mask[k] = (k > int'(last_grant_q));
    end
    upper_pending = pending_q & upper_mask;
    for (int k = N - 1; k >= 0; k--) begin
      if (upper_pending[k]) sel_upper = MW'(k);
      if (pending_q[k])     sel_any   = MW'(k);
    end
    sel = (upper_pending != '0) ? sel_upper : sel_any;
  end

  // FSM next state and per-cycle events; done wins over a simultaneous timeout
  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    accept     = 1'b0;
    timed_out  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          grant_fire = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core.done) begin
          accept  = enable[motor_id_q];
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          timed_out = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request bookkeeping: a request landing on the granted channel re-arms it instead of overrunning
  always_comb begin
    grant_vec   = '0;
    accept_vec  = '0;
    overrun_inc = '0;
    for (int k = 0; k < N; k++) begin
      grant_vec[k]  = grant_fire && (sel == MW'(k));
      accept_vec[k] = accept && (motor_id_q == MW'(k));
    end
    req_valid   = update_request & enable;
    overrun_vec = req_valid & pending_q & ~grant_vec;
    pending_d   = enable & ((pending_q & ~grant_vec) | req_valid);
    for (int k = 0; k < N; k++) begin
      overrun_inc = overrun_inc + 32'(overrun_vec[k]);
    end
    overrun_sum = {1'b0, overrun_q} + {1'b0, overrun_inc};
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending set, grant bookkeeping and WAIT timer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q    <= '0;
      motor_id_q   <= '0;
      last_grant_q <= MW'(N - 1);
      timer_q      <= '0;
    end else begin
      pending_q <= pending_d;
      if (grant_fire) begin
        motor_id_q   <= sel;
        last_grant_q <= sel;
      end
      if (state_q == ST_ISSUE) begin
        timer_q <= '0;
      end else if (state_q == ST_WAIT) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  // Duty registers: disabled channels are held at zero, accepted results land one cycle after done
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      duty_q       <= '0;
      duty_valid_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!enable[k]) begin
          duty_q[k] <= '0;
        end else if (accept_vec[k]) begin
          duty_q[k] <= core.result_duty;
        end
      end
      duty_valid_q <= accept_vec;
    end
  end

  // Saturating diagnostic counters; clear beats a same-cycle increment
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= '0;
      timeout_q <= '0;
    end else if (clear_counters) begin
      overrun_q <= '0;
      timeout_q <= '0;
    end else begin
      overrun_q <= overrun_sum[32] ? '1 : overrun_sum[31:0];
      if (timed_out && (timeout_q != '1)) begin
        timeout_q <= timeout_q + 16'd1;
      end
    end
  end

  assign core.start    = (state_q == ST_ISSUE);
  assign core.motor_id = motor_id_q;
  assign busy          = (state_q != ST_IDLE);
  assign duty          = duty_q;
  assign duty_valid    = duty_valid_q;
  assign overrun_count = overrun_q;
  assign timeout_count = timeout_q;

endmodule

// File: tb/tb_msj_pid_update_scheduler.sv
// tb/tb_msj_pid_update_scheduler.sv - scoreboard bench for the PID update scheduler
module tb_msj_pid_update_scheduler;

  localparam int N = 8;

  logic         clock;
  logic         reset_n;
  logic [N-1:0] update_request;
  logic [N-1:0] enable;
  logic [255:0] duty;
  logic [N-1:0] duty_valid;
  logic         busy;
  logic [31:0]  overrun_count;
  logic [15:0]  timeout_count;
  logic         clear_counters;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          motor;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  msj_pid_update_scheduler_if #(.MOTOR_ID_WIDTH(3)) core_if ();

  msj_pid_update_scheduler #(
    .NUMBER_OF_MOTORS(8),
    .MOTOR_ID_WIDTH  (3),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .update_request(update_request),
    .enable        (enable),
    .core          (core_if.master),
    .duty          (duty),
    .duty_valid    (duty_valid),
    .busy          (busy),
    .overrun_count (overrun_count),
    .timeout_count (timeout_count),
    .clear_counters(clear_counters)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard: every duty_valid pulse must match the oldest expected result
  always @(negedge clock) begin
    if (reset_n && duty_valid !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL duty_valid_unexpected got=%b expected=none", duty_valid);
      end else begin
        e = sb.pop_front();
        if (duty_valid !== (8'd1 << e.motor) || duty[e.motor*32 +: 32] !== e.val) begin
          failures++;
          $display("FAIL scoreboard got valid=%b duty=%0d expected valid motor=%0d duty=%0d",
                   duty_valid, duty[e.motor*32 +: 32], e.motor, e.val);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_req(input logic [N-1:0] m);
    update_request = m;
    step();
    update_request = '0;
  endtask

  task automatic do_reset();
    reset_n            = 1'b0;
    update_request     = '0;
    enable             = '1;
    clear_counters     = 1'b0;
    core_if.done       = 1'b0;
    core_if.result_duty = '0;
    sb.delete();
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_start(output bit ok, output logic [2:0] id);
    ok = 1'b0;
    id = '0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clock);
      if (core_if.start) begin
        ok = 1'b1;
        id = core_if.motor_id;
      end
    end
  endtask

  task automatic serve(input int exp_id, input logic [31:0] val, input int lat);
    bit ok;
    logic [2:0] id;
    wait_start(ok, id);
    checks++;
    if (!ok || id !== 3'(exp_id)) begin
      failures++;
      $display("FAIL grant got ok=%0d id=%0d expected id=%0d", ok, id, exp_id);
    end
    if (ok) begin
      repeat (lat) step();
      core_if.done        = 1'b1;
      core_if.result_duty = val;
      sb.push_back('{exp_id, val});
      step();
      core_if.done = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n            = 1'b0;
    update_request     = '0;
    enable             = '1;
    clear_counters     = 1'b0;
    core_if.done       = 1'b0;
    core_if.result_duty = '0;
    step();
    step();
    checks++;
    if (core_if.start !== 1'b0 || busy !== 1'b0 || core_if.motor_id !== 3'd0 || duty !== '0 ||
        duty_valid !== '0 || overrun_count !== 32'd0 || timeout_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state got start=%b busy=%b id=%0d valid=%b ovr=%0d tmo=%0d expected all zero",
               core_if.start, busy, core_if.motor_id, duty_valid, overrun_count, timeout_count);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    update_request = 8'b0000_0100;
    for (int t = 1; t <= 7; t++) begin
      step();
      if (t == 1) update_request = '0;
      if (t == 6) begin
        core_if.done        = 1'b1;
        core_if.result_duty = 32'd123;
        sb.push_back('{2, 32'd123});
      end
      if (t == 7) core_if.done = 1'b0;
      @(negedge clock);
      checks++;
      if (core_if.start !== (t == 2)) begin
        failures++;
        $display("FAIL single_start t=%0d got=%b expected=%b", t, core_if.start, (t == 2));
      end
      checks++;
      if (busy !== (t >= 2 && t <= 6)) begin
        failures++;
        $display("FAIL single_busy t=%0d got=%b expected=%b", t, busy, (t >= 2 && t <= 6));
      end
      if (t == 2) begin
        checks++;
        if (core_if.motor_id !== 3'd2) begin
          failures++;
          $display("FAIL single_motor_id got=%0d expected=2", core_if.motor_id);
        end
      end
    end
    step();
    checks++;
    if (sb.size() != 0 || duty[95:64] !== 32'd123) begin
      failures++;
      $display("FAIL single_result got pending=%0d duty2=%0d expected pending=0 duty2=123",
               sb.size(), duty[95:64]);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    pulse_req(8'b0010_1001);
    serve(0, 32'd10, 1);
    serve(3, 32'd30, 2);
    serve(5, -32'sd50, 1);
    pulse_req(8'b0000_0011);
    serve(0, 32'd11, 3);
    serve(1, 32'd21, 1);
    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rr_drain got pending=%0d expected=0", sb.size());
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [2:0] id;
    int starts;
    do_reset();
    pulse_req(8'b0000_0001);
    wait_start(ok, id);
    checks++;
    if (!ok || id !== 3'd0) begin
      failures++;
      $display("FAIL overrun_first_grant got ok=%0d id=%0d expected id=0", ok, id);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      pulse_req(8'b0001_0000);
      step();
    end
    core_if.done        = 1'b1;
    core_if.result_duty = 32'd7;
    sb.push_back('{0, 32'd7});
    step();
    core_if.done = 1'b0;
    serve(4, 32'd44, 1);
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (core_if.start) starts++;
    end
    checks++;
    if (starts != 0) begin
      failures++;
      $display("FAIL overrun_single_service got extra_starts=%0d expected=0", starts);
    end
    checks++;
    if (overrun_count !== 32'd2) begin
      failures++;
      $display("FAIL overrun_count got=%0d expected=2", overrun_count);
    end
    step();
    clear_counters = 1'b1;
    step();
    clear_counters = 1'b0;
    @(negedge clock);
    checks++;
    if (overrun_count !== 32'd0) begin
      failures++;
      $display("FAIL overrun_clear got=%0d expected=0", overrun_count);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [2:0] id;
    do_reset();
    pulse_req(8'b0000_0100);
    serve(2, 32'd55, 2);
    pulse_req(8'b0000_0100);
    wait_start(ok, id);
    checks++;
    if (!ok || id !== 3'd2) begin
      failures++;
      $display("FAIL timeout_grant got ok=%0d id=%0d expected id=2", ok, id);
    end
    for (int t = 1; t <= 18; t++) begin
      step();
      if (t == 1) update_request = 8'b0100_0000;
      if (t == 2) update_request = '0;
      @(negedge clock);
      if (t >= 15 && t <= 17) begin
        checks++;
        if (busy !== (t <= 16)) begin
          failures++;
          $display("FAIL timeout_busy t=%0d got=%b expected=%b", t, busy, (t <= 16));
        end
      end
      if (t == 17) begin
        checks++;
        if (timeout_count !== 16'd1 || duty[95:64] !== 32'd55) begin
          failures++;
          $display("FAIL timeout_count got=%0d duty2=%0d expected count=1 duty2=55",
                   timeout_count, duty[95:64]);
        end
      end
      if (t == 18) begin
        checks++;
        if (core_if.start !== 1'b1 || core_if.motor_id !== 3'd6) begin
          failures++;
          $display("FAIL timeout_next_grant got start=%b id=%0d expected start=1 id=6",
                   core_if.start, core_if.motor_id);
        end
      end
    end
    step();
    core_if.done        = 1'b1;
    core_if.result_duty = 32'd66;
    sb.push_back('{6, 32'd66});
    step();
    core_if.done = 1'b0;
    step();
  endtask

  task automatic test_disable();
    bit ok;
    logic [2:0] id;
    int starts;
    do_reset();
    pulse_req(8'b0000_0010);
    serve(1, 32'd500, 1);
    pulse_req(8'b0000_0010);
    wait_start(ok, id);
    checks++;
    if (!ok || id !== 3'd1) begin
      failures++;
      $display("FAIL disable_grant got ok=%0d id=%0d expected id=1", ok, id);
    end
    step();
    enable = 8'b1111_1101;
    step();
    core_if.done        = 1'b1;
    core_if.result_duty = 32'd77;
    step();
    core_if.done = 1'b0;
    @(negedge clock);
    checks++;
    if (duty[63:32] !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL disable_discard got duty1=%0d busy=%b expected duty1=0 busy=0", duty[63:32], busy);
    end
    pulse_req(8'b0000_0010);
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (core_if.start) starts++;
    end
    checks++;
    if (starts != 0 || overrun_count !== 32'd0) begin
      failures++;
      $display("FAIL disable_ignore got starts=%0d ovr=%0d expected starts=0 ovr=0", starts, overrun_count);
    end
    enable = '1;
    step();
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    logic [2:0] id;
    do_reset();
    pulse_req(8'b0000_1000);
    serve(3, 32'd9, 1);
    pulse_req(8'b0000_1000);
    wait_start(ok, id);
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || core_if.start !== 1'b0 || core_if.motor_id !== 3'd0 ||
        duty !== '0 || duty_valid !== '0) begin
      failures++;
      $display("FAIL async_reset got busy=%b start=%b id=%0d valid=%b expected all zero",
               busy, core_if.start, core_if.motor_id, duty_valid);
    end
    step();
    reset_n = 1'b1;
    step();
    core_if.done        = 1'b1;
    core_if.result_duty = 32'd99;
    step();
    core_if.done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || duty !== '0) begin
        failures++;
        $display("FAIL post_reset_done i=%0d got busy=%b expected busy=0 duty=0", i, busy);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overrun();
    test_timeout();
    test_disable();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msj_pid_update_scheduler.md
Name: msj_pid_update_scheduler

Overview:
- Time-multiplexes one shared PID arithmetic core across NUMBER_OF_MOTORS motor channels on the MSJ platform.
- Collects per-motor update requests (sensor cycle pulses or forced updates) and grants them round-robin, one at a time, to the core.
- Runs the start/done handshake with the core, with a timeout.
- Holds per-motor duty registers and pulses duty_valid to the PWM generators.

Parameters:
NUMBER_OF_MOTORS, 8, number of requesting channels
MOTOR_ID_WIDTH, 3, width of motor_id; must be >= clog2(NUMBER_OF_MOTORS)
TIMEOUT_CYCLES, 1024, WAIT cycles allowed before abandoning a core operation (>=2)

Ports:
clock  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
update_request  in  NUMBER_OF_MOTORS  per-motor single-cycle request pulses
enable  in  NUMBER_OF_MOTORS  per-motor enable mask
start  out  1  one-cycle pulse launching the shared core
motor_id  out  MOTOR_ID_WIDTH  channel being serviced; stable from start until return to IDLE
done  in  1  one-cycle completion pulse from the core
result_duty  in  32  signed core result; valid while done=1
duty  out  32*NUMBER_OF_MOTORS  packed signed duty registers, motor k at bits [32k+31:32k]
duty_valid  out  NUMBER_OF_MOTORS  one-cycle pulse per motor when duty[k] is updated
busy  out  1  high when state != IDLE
overrun_count  out  32  saturating count of dropped duplicate requests
timeout_count  out  16  saturating count of timed-out operations
clear_counters  in  1  synchronous clear of both counters

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; pending=0; last_grant=NUMBER_OF_MOTORS-1; motor_id=0; all duty=0; duty_valid=0; start=0; busy=0; both counters=0; WAIT timer=0.
- Pending capture: update_request[k]&enable[k] sets pending[k] at the next edge.
  - If pending[k] is already set and not being granted this cycle: request dropped, overrun_count+1.
  - If a request for k arrives in the same cycle k is granted: pending[k] stays set, no overrun.
  - Requests with enable[k]=0 are ignored and not counted.
- enable[k]=0: clears pending[k]; duty[k] forced to 0 at the next edge; no duty_valid pulse.
- FSM:
  - IDLE: if pending is non-zero, pick the first set bit searching from last_grant+1 upward, wrapping at NUMBER_OF_MOTORS-1 to 0. Load motor_id and last_grant with it, clear pending[sel], go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: start=1 for exactly this cycle. Clear the timer, go to WAIT.
  - WAIT: timer increments each cycle.
    - If done=1 and enable[motor_id]=1: duty[motor_id]<=result_duty; duty_valid[motor_id]=1 in the following cycle; go to IDLE.
    - If done=1 and enable[motor_id]=0: discard the result, go to IDLE.
    - Else if timer==TIMEOUT_CYCLES-1: timeout_count+1, duty unchanged, go to IDLE.
    - done and timeout in the same cycle: done wins.
- done outside WAIT is ignored.
- Latency:
  - Request pulse in cycle c with an idle scheduler gives start in cycle c+2.
  - done in cycle d gives duty/duty_valid in d+1; the next start is at the earliest d+2.
  - Minimum service period is 3 cycles plus core latency.
- start, duty_valid and busy are decoded from registered state (glitch-free). duty_valid has at most one bit set at a time.
- Counters saturate at all-ones. clear_counters has priority over a simultaneous increment.
- Width rules: duty is stored as full 32-bit signed with no truncation. motor_id values >= NUMBER_OF_MOTORS never occur.

Test Plan:
1. Single request: pulse update_request[2] in cycle 10; core returns done at cycle 16 with result_duty=123 -> start high in cycle 12 only, motor_id=2, busy cycles 12-16, duty[2]=123 and duty_valid=8'b0000_0100 in cycle 17.
2. Round-robin: pulse requests 0, 3 and 5 together -> grants in order 0, 3, 5. Then pulse 1 and 0 together -> order 0, 1 (search resumes at 6 and wraps).
3. Overrun: stall the core, pulse update_request[4] three times while pending[4] is set -> overrun_count=2, motor 4 serviced once. Then clear_counters -> overrun_count=0.
4. Timeout: TIMEOUT_CYCLES=16, never assert done -> return to IDLE after 16 WAIT cycles, timeout_count=1, duty unchanged. The queued request for motor 6 then issues start with motor_id=6.
5. Disable mid-service: drop enable[1] during WAIT for motor 1; done arrives with result 77 -> duty[1]=0, no duty_valid pulse, FSM returns to IDLE.
6. Reset mid-WAIT: assert reset_n=0 asynchronously -> all outputs zero immediately. A done pulse arriving after release is ignored and busy stays 0.
